// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter state encoding, default byte width
// and width helpers used to size indices and counters.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Bits needed to index n items (at least 1).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold 0..max_val inclusive (at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client lanes plus TX FIFO write port of the UART transmit arbiter.
// slave: the arbiter's view; master: the clients/FIFO side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned ID_BITS    = idx_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         W_data;
  logic                          wr_uart;
  logic                          tx_full;
  logic                          busy;
  logic [ID_BITS-1:0]            grant_id;
  logic                          stall_abort;

  modport slave (
    input  req_valid, req_last, req_data, tx_full,
    output req_ready, W_data, wr_uart, busy, grant_id, stall_abort
  );

  modport master (
    output req_valid, req_last, req_data, tx_full,
    input  req_ready, W_data, wr_uart, busy, grant_id, stall_abort
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping past the top index.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_BITS = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_BITS-1:0] rr_ptr,
  output logic               any_req,
  output logic [ID_BITS-1:0] pick_idx
);

  int unsigned idx;
  logic        found;

  always_comb begin
    any_req  = |req;
    pick_idx = rr_ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[ID_BITS-1:0]]) begin
        found    = 1'b1;
        pick_idx = idx[ID_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the UART TX FIFO write port
// among NUM_REQ byte-stream clients, with a stall watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int unsigned STALL_LIMIT = 255,
  parameter int unsigned ID_BITS     = idx_width(NUM_REQ)
) (
  input logic               UCLK,
  input logic               reset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(STALL_LIMIT);

  arb_state_e         state_q, state_d;
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_BITS-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               busy_q, busy_d;
  logic               abort_q, abort_d;

  logic                  any_req;
  logic [ID_BITS-1:0]    pick_idx;
  logic [DATA_WIDTH-1:0] lane [NUM_REQ];
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;
  logic [ID_BITS-1:0]    next_ptr;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_pick (
    .req      (bus.req_valid),
    .rr_ptr   (rr_ptr_q),
    .any_req  (any_req),
    .pick_idx (pick_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Datapath toward the FIFO stays combinational so a held byte moves the
  // same cycle tx_full drops.
  always_comb begin
    sel_valid     = bus.req_valid[grant_q];
    sel_last      = bus.req_last[grant_q];
    sel_data      = lane[grant_q];
    xfer          = (state_q == XFER) && sel_valid && !bus.tx_full;
    bus.req_ready = '0;
    bus.W_data    = '0;
    if (state_q == XFER) begin
      bus.req_ready[grant_q] = !bus.tx_full;
      bus.W_data             = sel_data;
    end
    bus.wr_uart     = xfer;
    bus.busy        = busy_q;
    bus.grant_id    = grant_q;
    bus.stall_abort = abort_q;
  end

  always_comb begin
    next_ptr    = (grant_q == ID_BITS'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    stall_cnt_d = stall_cnt_q;
    busy_d      = busy_q;
    abort_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d     = pick_idx;
          state_d     = XFER;
          busy_d      = 1'b1;
          stall_cnt_d = '0;
        end
      end
      XFER: begin
        // A transfer outranks an expired watchdog in the same cycle.
        if (xfer) begin
          stall_cnt_d = '0;
          if (sel_last) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            rr_ptr_d = next_ptr;
          end
        end else if (stall_cnt_q >= CNT_W'(STALL_LIMIT)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = next_ptr;
          abort_d  = 1'b1;
        end else if (sel_valid) begin
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UCLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      stall_cnt_q <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      stall_cnt_q <= stall_cnt_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: client queues feed the lanes, a
// scoreboard holds the bytes expected on the FIFO write port in order.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_BITS(2)) bus_if ();

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (DW),
    .STALL_LIMIT (4),
    .ID_BITS     (2)
  ) dut (
    .UCLK  (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  int unsigned vec = 0;
  int unsigned err = 0;
  int unsigned aborts = 0;

  logic [8:0]  cq [N][$];   // per-client {last, data}
  logic [15:0] sb [$];      // expected {lane, data}
  logic        acc [N];
  logic        txf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    logic [N-1:0]    v;
    logic [N-1:0]    l;
    logic [N*DW-1:0] d;
    logic [8:0]      h;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (cq[i].size() > 0) begin
        h = cq[i][0];
        v[i] = 1'b1;
        l[i] = h[8];
        d[i*DW +: DW] = h[7:0];
      end
    end
    bus_if.req_valid = v;
    bus_if.req_last  = l;
    bus_if.req_data  = d;
    bus_if.tx_full   = txf;
  endtask

  task automatic push(input int lane, input logic [7:0] data, input logic last);
    cq[lane].push_back({last, data});
    sb.push_back({8'(lane), data});
  endtask

  // One clock: drive at posedge+1, sample and score at the following negedge.
  task automatic tick();
    logic [8:0]  h;
    logic [15:0] e;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && cq[i].size() > 0) h = cq[i].pop_front();
    drive_pins();
    @(negedge clk);
    for (int i = 0; i < N; i++) acc[i] = bus_if.req_valid[i] && bus_if.req_ready[i];
    if (bus_if.stall_abort) aborts++;
    if (bus_if.wr_uart) begin
      chk("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("w_data", bus_if.W_data, e[7:0]);
        chk("w_lane", bus_if.grant_id, e[15:8]);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    txf   = 1'b0;
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    drive_pins();
    tick(); tick();
    chk("rst_busy",  bus_if.busy, 0);
    chk("rst_wr",    bus_if.wr_uart, 0);
    chk("rst_abort", bus_if.stall_abort, 0);
    chk("rst_ready", bus_if.req_ready, 0);
    chk("rst_wdata", bus_if.W_data, 0);
    chk("rst_gid",   bus_if.grant_id, 0);
    reset = 1'b0;

    // Reset while client 1 is mid-message
    push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b0);
    cq[1].push_back({1'b0, 8'h13});
    cq[1][2] = {1'b1, 8'h13};
    tick();
    chk("m_arb_busy", bus_if.busy, 0);
    tick(); tick();
    chk("m_mid_busy", bus_if.busy, 1);
    reset = 1'b1;
    cq[1].delete();
    for (int i = 0; i < N; i++) acc[i] = 1'b0;
    drive_pins();
    #1;
    chk("m_rst_busy",  bus_if.busy, 0);
    chk("m_rst_wr",    bus_if.wr_uart, 0);
    chk("m_rst_abort", bus_if.stall_abort, 0);
    chk("m_rst_ready", bus_if.req_ready, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("m_post_busy", bus_if.busy, 0);
    chk("m_post_gid",  bus_if.grant_id, 0);

    // Round robin among 0,1,3 with held 1-byte messages
    push(0, 8'hA0, 1'b1); push(1, 8'hB0, 1'b1); push(3, 8'hD0, 1'b1);
    push(0, 8'hA1, 1'b1); push(1, 8'hB1, 1'b1); push(3, 8'hD1, 1'b1);
    drain("rr_drain", 40);
    tick();
    chk("rr_idle", bus_if.busy, 0);
    chk("rr_cq_empty", cq[0].size() + cq[1].size() + cq[3].size(), 0);

    // Single client 2, no back-pressure
    push(2, 8'h41, 1'b0); push(2, 8'h42, 1'b0); push(2, 8'h43, 1'b1);
    tick();
    chk("s_arb_busy", bus_if.busy, 0);
    chk("s_arb_wr",   bus_if.wr_uart, 0);
    tick();
    chk("s_busy", bus_if.busy, 1);
    chk("s_gid",  bus_if.grant_id, 2);
    chk("s_wr0",  bus_if.wr_uart, 1);
    tick(); chk("s_wr1", bus_if.wr_uart, 1);
    tick(); chk("s_wr2", bus_if.wr_uart, 1);
    tick();
    chk("s_done_busy", bus_if.busy, 0);
    chk("s_done_wr",   bus_if.wr_uart, 0);
    chk("s_sb", sb.size(), 0);

    // Back-pressure inside a 4-byte message from client 0
    push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b1);
    tick(); tick();
    chk("bp_first_wr", bus_if.wr_uart, 1);
    txf = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_full_wr",    bus_if.wr_uart, 0);
      chk("bp_full_ready", bus_if.req_ready[0], 0);
      chk("bp_full_abort", bus_if.stall_abort, 0);
      chk("bp_full_busy",  bus_if.busy, 1);
    end
    txf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_resume_wr", bus_if.wr_uart, 1);
    end
    tick();
    chk("bp_done_busy", bus_if.busy, 0);
    chk("bp_sb", sb.size(), 0);

    // Watchdog: client 1 stalls mid-message, client 2 waiting
    push(1, 8'h21, 1'b0); push(2, 8'h31, 1'b1);
    tick();
    tick();
    chk("wd_gid1", bus_if.grant_id, 1);
    chk("wd_wr",   bus_if.wr_uart, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("wd_hold_abort", bus_if.stall_abort, 0);
      chk("wd_hold_busy",  bus_if.busy, 1);
    end
    tick();
    chk("wd_abort", bus_if.stall_abort, 1);
    chk("wd_abort_busy", bus_if.busy, 0);
    tick();
    chk("wd_abort_once", bus_if.stall_abort, 0);
    chk("wd_regrant_busy", bus_if.busy, 1);
    chk("wd_regrant_gid", bus_if.grant_id, 2);
    tick();
    chk("wd_sb", sb.size(), 0);

    // Last byte on the cycle the watchdog expires, then immediate re-request
    push(1, 8'h51, 1'b0);
    tick(); tick();
    chk("c_gid", bus_if.grant_id, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("c_hold_abort", bus_if.stall_abort, 0);
    end
    push(1, 8'h52, 1'b1); push(1, 8'h53, 1'b1);
    tick();
    chk("c_last_wr", bus_if.wr_uart, 1);
    tick();
    chk("c_no_abort", bus_if.stall_abort, 0);
    chk("c_idle_busy", bus_if.busy, 0);
    chk("c_idle_wr", bus_if.wr_uart, 0);
    tick();
    chk("c_regrant_busy", bus_if.busy, 1);
    chk("c_regrant_gid", bus_if.grant_id, 1);
    chk("c_regrant_wr", bus_if.wr_uart, 1);
    tick();
    chk("c_end_busy", bus_if.busy, 0);
    chk("c_sb", sb.size(), 0);
    chk("abort_total", aborts, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
